alu_wide: RTL and testbench

- Parametrised, multi-cycle successor to the core ALU.
- Provides operand latches, registered result/flags, a start/busy/done handshake, and digit-serial BCD add/subtract.
- Generalised to any nibble-multiple width.
- Sits between the internal buses and the accumulator/flag logic; bus steering is done outside this block.

---
 rtl/alu_wide_if.sv | 19 +
 rtl/alu_wide.sv | 132 +++++++++++++
 tb/tb_alu_wide.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_wide_if.sv
// alu_wide_if: operand, control, handshake and result/flag signals of alu_wide
//   master drives LOAD_A/LOAD_B/A_IN/B_IN/OP/CIN/n_DAA/n_DSA/START and reads BUSY/DONE/ADD/ACR/AVR/ZR/NR
//   slave is the ALU side
interface alu_wide_if #(
   parameter int WIDTH = 8
);
   logic LOAD_A, LOAD_B, CIN, n_DAA, n_DSA, START;
   logic [WIDTH-1:0] A_IN, B_IN, ADD;
   logic [2:0] OP;
   logic BUSY, DONE, ACR, AVR, ZR, NR;
   modport master (
      output LOAD_A, LOAD_B, A_IN, B_IN, OP, CIN, n_DAA, n_DSA, START,
      input BUSY, DONE, ADD, ACR, AVR, ZR, NR
   );
   modport slave (
      input LOAD_A, LOAD_B, A_IN, B_IN, OP, CIN, n_DAA, n_DSA, START,
      output BUSY, DONE, ADD, ACR, AVR, ZR, NR
   );
endinterface

// File: rtl/alu_wide.sv
// alu_wide: multi-cycle ALU with operand latches, registered result/flags and digit-serial BCD add/sub
//   PHI2 clock, n_RES async active-low reset
//   bus (alu_wide_if.slave): LOAD_A/LOAD_B/A_IN/B_IN operand latches, OP/CIN/n_DAA/n_DSA controls,
//   START/BUSY/DONE handshake, ADD result with ACR/AVR/ZR/NR flags
//   ALU_DECIMAL_EN: defined adds the DCORR state and decimal SUM/SUB; undefined gives binary-only SUM/SUB
module alu_wide #(
   parameter int WIDTH = 8
) (
   input logic PHI2,
   input logic n_RES,
   alu_wide_if.slave bus
);
`ifdef ALU_DECIMAL_EN
   localparam int DIGITS = WIDTH / 4;
   localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   typedef enum logic [1:0] {IDLE, EXEC, DCORR, FIN} state_t;
`else
   typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;
`endif
   state_t state;
   logic [WIDTH-1:0] ai, bi, add, b_op, res;
   logic [WIDTH:0] sum;
   logic [2:0] op_q;
   logic cin_q, acr, avr, zr, nr, busy, done, ovf, res_c, res_v;
   always_comb begin
      b_op = op_q[0] ? ~bi : bi;
      sum = {1'b0, ai} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin_q};
      ovf = (ai[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != ai[WIDTH-1]);
      res = op_q == 3'b000 ? ai & bi :
            op_q == 3'b001 ? ai ^ bi :
            op_q == 3'b010 ? ai | bi :
            op_q == 3'b011 ? {cin_q, ai[WIDTH-1:1]} :
            op_q[2:1] == 2'b10 ? sum[WIDTH-1:0] : '0;
      res_c = op_q == 3'b011 ? ai[0] : op_q[2:1] == 2'b10 ? sum[WIDTH] : 1'b0;
      res_v = op_q[2:1] == 2'b10 && ovf;
   end
`ifdef ALU_DECIMAL_EN
   logic [DW-1:0] dig;
   logic dc, dec_q, nc;
   logic [3:0] da, db, ds;
   logic [5:0] t;
   // one BCD digit per cycle; t is signed for subtraction, so t[5] marks a borrow
   always_comb begin
      da = ai[4*dig +: 4];
      db = bi[4*dig +: 4];
      t = op_q[0] ? 6'(da) - 6'(db) - 6'(!dc) : 6'(da) + 6'(db) + 6'(dc);
      nc = op_q[0] ? !t[5] : t > 6'd9;
      ds = op_q[0] ? t[3:0] + (t[5] ? 4'd10 : 4'd0) : t[3:0] + (nc ? 4'd6 : 4'd0);
   end
`else
   localparam logic dec_q = 1'b0;
   logic unused_dec;
   assign unused_dec = bus.n_DAA ^ bus.n_DSA;
`endif
   always_ff @(posedge PHI2 or negedge n_RES)
      if (!n_RES) begin
         state <= IDLE;
         ai <= '0;
         bi <= '0;
         add <= '0;
         op_q <= '0;
         cin_q <= 1'b0;
         acr <= 1'b0;
         avr <= 1'b0;
         zr <= 1'b0;
         nr <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
`ifdef ALU_DECIMAL_EN
         dig <= '0;
         dc <= 1'b0;
         dec_q <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.LOAD_A) ai <= bus.A_IN;
               if (bus.LOAD_B) bi <= bus.B_IN;
               if (bus.START) begin
                  state <= EXEC;
                  busy <= 1'b1;
                  op_q <= bus.OP;
                  cin_q <= bus.CIN;
`ifdef ALU_DECIMAL_EN
                  dec_q <= (bus.OP == 3'b100 && !bus.n_DAA) || (bus.OP == 3'b101 && !bus.n_DSA);
`endif
               end
            end
            EXEC: begin
               avr <= res_v;
               if (!dec_q) begin
                  add <= res;
                  acr <= res_c;
               end
`ifdef ALU_DECIMAL_EN
               dig <= '0;
               dc <= cin_q;
               state <= dec_q ? DCORR : FIN;
`else
               state <= FIN;
`endif
            end
`ifdef ALU_DECIMAL_EN
            DCORR: begin
               add[4*dig +: 4] <= ds;
               dc <= nc;
               dig <= dig + 1'b1;
               if (dig == DW'(DIGITS - 1)) begin
                  acr <= nc;
                  state <= FIN;
               end
            end
`endif
            FIN: begin
               zr <= add == '0;
               nr <= add[WIDTH-1];
               done <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   assign bus.ADD = add;
   assign bus.ACR = acr;
   assign bus.AVR = avr;
   assign bus.ZR = zr;
   assign bus.NR = nr;
   assign bus.BUSY = busy;
   assign bus.DONE = done;
endmodule

// File: tb/tb_alu_wide.sv
// tb_alu_wide: scoreboard bench for alu_wide at WIDTH=8 and WIDTH=16
module tb_alu_wide;
   typedef struct {
      logic [15:0] add;
      logic acr, avr, zr, nr;
      int cyc;
   } exp_t;
`ifdef ALU_DECIMAL_EN
   localparam bit DEC = 1'b1;
`else
   localparam bit DEC = 1'b0;
`endif
   logic PHI2 = 1'b0;
   logic n_RES = 1'b0;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   exp_t q8[$];
   exp_t q16[$];
   exp_t e8, e16;
   alu_wide_if #(.WIDTH(8)) b8 ();
   alu_wide_if #(.WIDTH(16)) b16 ();
   alu_wide #(.WIDTH(8)) u8 (.PHI2(PHI2), .n_RES(n_RES), .bus(b8));
   alu_wide #(.WIDTH(16)) u16 (.PHI2(PHI2), .n_RES(n_RES), .bus(b16));
   always #5 PHI2 = ~PHI2;
   always @(posedge PHI2) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", n, got, want);
      end
   endtask
   function automatic exp_t mk(input logic [15:0] add, input logic acr, avr, zr, nr, input int lat);
      exp_t r;
      r.add = add;
      r.acr = acr;
      r.avr = avr;
      r.zr = zr;
      r.nr = nr;
      r.cyc = lat;
      return r;
   endfunction
   // monitors: every DONE pops one expectation; result tuple includes BUSY which must be 0
   always @(negedge PHI2)
      if (b8.DONE) begin
         if (q8.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done8: got unexpected DONE at cycle %0d want none", cyc);
         end else begin
            e8 = q8.pop_front();
            chk("res8", {11'd0, 8'd0, b8.ADD, b8.ACR, b8.AVR, b8.ZR, b8.NR, b8.BUSY},
                {11'd0, e8.add, e8.acr, e8.avr, e8.zr, e8.nr, 1'b0});
            chk("lat8", cyc, e8.cyc);
         end
      end
   always @(negedge PHI2)
      if (b16.DONE) begin
         if (q16.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done16: got unexpected DONE at cycle %0d want none", cyc);
         end else begin
            e16 = q16.pop_front();
            chk("res16", {11'd0, b16.ADD, b16.ACR, b16.AVR, b16.ZR, b16.NR, b16.BUSY},
                {11'd0, e16.add, e16.acr, e16.avr, e16.zr, e16.nr, 1'b0});
            chk("lat16", cyc, e16.cyc);
         end
      end
   task automatic drive(input bit w, input logic [15:0] a, b, input logic [2:0] op,
                        input logic cin, ndaa, ndsa, la, lb, st);
      if (w) begin
         b16.A_IN = a;
         b16.B_IN = b;
         b16.OP = op;
         b16.CIN = cin;
         b16.n_DAA = ndaa;
         b16.n_DSA = ndsa;
         b16.LOAD_A = la;
         b16.LOAD_B = lb;
         b16.START = st;
      end else begin
         b8.A_IN = a[7:0];
         b8.B_IN = b[7:0];
         b8.OP = op;
         b8.CIN = cin;
         b8.n_DAA = ndaa;
         b8.n_DSA = ndsa;
         b8.LOAD_A = la;
         b8.LOAD_B = lb;
         b8.START = st;
      end
   endtask
   task automatic wait_empty(input string n, input bit w);
      for (int i = 0; i < 20 && (w ? q16.size() : q8.size()) != 0; i++) @(negedge PHI2);
      if ((w ? q16.size() : q8.size()) != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no DONE within 20 cycles want DONE", n);
         if (w) q16.delete();
         else q8.delete();
      end
   endtask
   // e.cyc holds the latency in edges after the START edge
   task automatic run(input string n, input bit w, input logic [15:0] a, b, input logic [2:0] op,
                      input logic cin, ndaa, ndsa, la, lb, input exp_t e);
      @(negedge PHI2);
      drive(w, a, b, op, cin, ndaa, ndsa, la, lb, 1'b1);
      @(posedge PHI2);
      #1;
      e.cyc += cyc;
      if (w) q16.push_back(e);
      else q8.push_back(e);
      @(negedge PHI2);
      drive(w, a, b, op, cin, ndaa, ndsa, 1'b0, 1'b0, 1'b0);
      wait_empty(n, w);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end
   initial begin
      exp_t e;
      drive(1'b0, 16'h0, 16'h0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'h0, 16'h0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge PHI2);
      chk("rst8", {b8.ADD, b8.ACR, b8.AVR, b8.ZR, b8.NR, b8.BUSY, b8.DONE}, 32'd0);
      chk("rst16", {b16.ADD, b16.ACR, b16.AVR, b16.ZR, b16.NR, b16.BUSY, b16.DONE}, 32'd0);
      n_RES = 1'b1;
      run("bin_sum", 0, 16'h7F, 16'h01, 3'b100, 0, 1, 1, 1, 1, mk(16'h80, 0, 1, 0, 1, 2));
      run("dec_sum", 0, 16'h58, 16'h46, 3'b100, 0, 0, 1, 1, 1,
          DEC ? mk(16'h04, 1, 1, 0, 0, 4) : mk(16'h9E, 0, 1, 0, 1, 2));
      run("dec_sub", 0, 16'h12, 16'h21, 3'b101, 1, 1, 0, 1, 1,
          DEC ? mk(16'h91, 0, 0, 0, 1, 4) : mk(16'hF1, 0, 0, 0, 1, 2));
      run("sub_daa_only", 0, 16'h12, 16'h21, 3'b101, 1, 0, 1, 1, 1, mk(16'hF1, 0, 0, 0, 1, 2));
      run("sr", 0, 16'h81, 16'h00, 3'b011, 1, 1, 1, 1, 1, mk(16'hC0, 1, 0, 0, 1, 2));
      run("and", 0, 16'hF0, 16'h0F, 3'b000, 0, 1, 1, 1, 1, mk(16'h00, 0, 0, 1, 0, 2));
      run("eor", 0, 16'hA5, 16'hFF, 3'b001, 0, 1, 1, 1, 1, mk(16'h5A, 0, 0, 0, 0, 2));
      run("or", 0, 16'h30, 16'h05, 3'b010, 0, 1, 1, 1, 1, mk(16'h35, 0, 0, 0, 0, 2));
      run("bin_sub", 0, 16'h50, 16'h30, 3'b101, 1, 1, 1, 1, 1, mk(16'h20, 1, 0, 0, 0, 2));
      run("sub_ovf", 0, 16'h80, 16'h01, 3'b101, 1, 1, 1, 1, 1, mk(16'h7F, 1, 1, 0, 0, 2));
      run("sum_cin", 0, 16'hFF, 16'h00, 3'b100, 1, 1, 1, 1, 1, mk(16'h00, 1, 0, 1, 0, 2));
      run("rsvd", 0, 16'hFF, 16'hFF, 3'b110, 1, 1, 1, 1, 1, mk(16'h00, 0, 0, 1, 0, 2));
      // START/LOAD_A held while busy must be ignored
      @(negedge PHI2);
      drive(0, 16'h10, 16'h20, 3'b100, 0, 1, 1, 1, 1, 1);
      @(posedge PHI2);
      #1;
      e = mk(16'h30, 0, 0, 0, 0, 2);
      e.cyc += cyc;
      q8.push_back(e);
      @(negedge PHI2);
      chk("busy", {31'd0, b8.BUSY}, 32'd1);
      drive(0, 16'h55, 16'h20, 3'b000, 0, 1, 1, 1, 0, 1);
      repeat (2) @(negedge PHI2);
      drive(0, 16'h55, 16'h20, 3'b000, 0, 1, 1, 0, 0, 0);
      wait_empty("handshake", 0);
      repeat (4) @(negedge PHI2);
      run("hold_ops", 0, 16'h00, 16'h00, 3'b010, 0, 1, 1, 0, 0, mk(16'h30, 0, 0, 0, 0, 2));
      // reset while the decimal op is in flight
      @(negedge PHI2);
      drive(0, 16'h58, 16'h46, 3'b100, 0, 0, 1, 1, 1, 1);
      @(posedge PHI2);
      @(negedge PHI2);
      drive(0, 16'h58, 16'h46, 3'b100, 0, 0, 1, 0, 0, 0);
      @(posedge PHI2);
      #2 n_RES = 1'b0;
      #1 chk("rst_mid", {b8.ADD, b8.ACR, b8.AVR, b8.ZR, b8.NR, b8.BUSY, b8.DONE}, 32'd0);
      @(negedge PHI2);
      n_RES = 1'b1;
      repeat (8) @(negedge PHI2);
      run("post_rst", 0, 16'h01, 16'h01, 3'b100, 0, 1, 1, 1, 1, mk(16'h02, 0, 0, 0, 0, 2));
      run("dec16_sum", 1, 16'h9999, 16'h0001, 3'b100, 0, 0, 1, 1, 1,
          DEC ? mk(16'h0000, 1, 0, 1, 0, 6) : mk(16'h999A, 0, 0, 0, 1, 2));
      run("bin16_sum", 1, 16'hFFFF, 16'h0001, 3'b100, 0, 1, 1, 1, 1, mk(16'h0000, 1, 0, 1, 0, 2));
      run("dec16_sub", 1, 16'h1000, 16'h0001, 3'b101, 1, 1, 0, 1, 1,
          DEC ? mk(16'h0999, 1, 0, 0, 0, 6) : mk(16'h0FFF, 1, 0, 0, 0, 2));
      repeat (4) @(negedge PHI2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
